servant_uart_rx: RTL and testbench
==================================

SERVANT_UART_RX -- requirements
Module: servant_uart_rx

Interface
REQ-001 The block SHALL take parameter CLKS_PER_BIT, default 278, meaning system clocks per serial bit (min 8).
REQ-002 The block SHALL take parameter FIFO_AW, default 2, meaning log2 of receive FIFO depth (4 entries).
REQ-003 The block SHALL have port i_wb_clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port i_wb_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port i_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 The block SHALL have port i_wb_adr, input, 1 bit: 0 selects DATA, 1 selects STATUS.
REQ-007 The block SHALL have port i_wb_dat, input, 32 bits: write data.
REQ-008 The block SHALL have port i_wb_we, input, 1 bit: write enable.
REQ-009 The block SHALL have port i_wb_cyc, input, 1 bit: bus cycle request.
REQ-010 The block SHALL have port o_wb_rdt, output, 32 bits: read data.
REQ-011 The block SHALL have port o_wb_ack, output, 1 bit: one-cycle acknowledge.
REQ-012 The block SHALL have port o_irq, output, 1 bit: high while the FIFO is non-empty.

Function
REQ-013 i_rx SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
REQ-014 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-015 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-016 IDLE->START SHALL occur on the first cycle rx_s is 0; the bit counter loads CLKS_PER_BIT/2 (integer division).
REQ-017 In START at counter expiry: rx_s=0 -> DATA, counter reloads CLKS_PER_BIT; rx_s=1 -> IDLE (glitch, nothing recorded).
REQ-018 In DATA, each counter expiry SHALL sample rx_s into the shift register; after the 8th sample -> STOP.
REQ-019 In STOP at counter expiry: rx_s=1 -> push byte into the FIFO; rx_s=0 -> set sticky FERR and drop the byte. Either way -> IDLE on the same edge.
REQ-020 A push while the FIFO is full SHALL drop the byte and set sticky OVR, unless a pop occurs in the same cycle, in which case the push succeeds and OVR stays unchanged.
REQ-021 The FIFO SHALL be a circular buffer with FIFO_AW-bit pointers and a (FIFO_AW+1)-bit count; pointers wrap modulo depth.
REQ-022 Wishbone: o_wb_ack SHALL assert for exactly one cycle, the cycle after i_wb_cyc is sampled high with o_wb_ack low; o_wb_rdt is valid in the ack cycle.
REQ-023 A read of DATA SHALL return {23'b0, valid, byte}, where valid = FIFO non-empty and byte is the head entry (0 if empty); a non-empty read pops exactly once, on the ack edge.
REQ-024 A read of STATUS SHALL return {24'b0, count[3:0], FERR, OVR, full, nonempty}, with count zero-extended/truncated to 4 bits.
REQ-025 A write to STATUS SHALL clear OVR if i_wb_dat[2]=1 and FERR if i_wb_dat[3]=1 (write-1-to-clear); set-by-hardware SHALL win over a clear in the same cycle.
REQ-026 Writes to DATA SHALL be acknowledged and have no effect.
REQ-027 o_irq SHALL be registered FIFO non-empty, updating the cycle after a push or pop.
REQ-028 Latency SHALL be: the byte becomes readable (o_irq high) on the cycle after the STOP sample edge.

Reset
REQ-029 While i_wb_rst_n=0 at a clock edge, the block SHALL set the FSM to IDLE, counters and FIFO pointers/count to 0, OVR=FERR=0, o_wb_ack=0, o_wb_rdt=0, o_irq=0, and the synchronizer flops to 1.
REQ-030 Reset mid-frame SHALL discard the partial byte; the frame in progress at reset release is not received unless a new falling edge occurs.

Verification
REQ-031 CLKS_PER_BIT=16: send 0xA5 -> o_irq rises; DATA read returns 0x1A5; next DATA read returns 0x000 and o_irq is low.
REQ-032 Send 0x00 with the stop bit forced to 0 -> FIFO stays empty; STATUS bit3=1; write 0x8 to STATUS -> STATUS reads 0x00.
REQ-033 Send 5 bytes 0x01..0x05 with no reads (depth 4) -> STATUS reads 0x47 (count 4, OVR, full, nonempty); DATA reads return 0x101..0x104.
REQ-034 Pulse i_rx low for 4 clocks (less than a half bit) -> FSM returns to IDLE; no push; STATUS reads 0x00.
REQ-035 Assert i_wb_rst_n=0 during the 4th data bit, then release -> STATUS reads 0x00, o_irq=0, and the next full frame 0x3C is received correctly.
REQ-036 Fill the FIFO, then align a DATA read pop with the STOP push of a 5th byte -> OVR remains 0 and count stays 4; wrap-around order is preserved on the subsequent reads.

Source files
------------

// File: rtl/servant_uart_rx.sv
// servant_uart_rx: 8N1 UART receiver with a small receive FIFO behind a two-register Wishbone slave
module servant_uart_rx #(
  parameter int CLKS_PER_BIT = 278,
  parameter int FIFO_AW = 2
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst_n,
  input  logic        i_rx,
  input  logic        i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_irq
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int NW = FIFO_AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic rx_meta_q, rx_s_q;
  logic expired, push, frame_err;
  logic [7:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_q, rd_q;
  logic [NW-1:0] count_q, count_d;
  logic ovr_q, ovr_d, ferr_q, ferr_d, irq_q, ack_q;
  logic [31:0] rdt_q, rdt_d;
  logic bus_start, nonempty, full, pop, push_ok, clr_wr;
  logic unused_dat;
  assign unused_dat = ^{i_wb_dat[31:4], i_wb_dat[1:0]};
  assign expired = cnt_q <= CW'(1);
  // Bit timing: the counter reaches 1 exactly on the mid-bit sample edge
  always_comb begin
    state_d = state_q;
    cnt_d = (state_q == IDLE) ? cnt_q : cnt_q - CW'(1);
    bit_d = bit_q;
    shift_d = shift_q;
    push = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      IDLE: if (!rx_s_q) begin
        state_d = START;
        cnt_d = HALF_BIT;
      end
      START: if (expired) begin
        state_d = rx_s_q ? IDLE : DATA;
        cnt_d = FULL_BIT;
        bit_d = 3'd0;
      end
      DATA: if (expired) begin
        shift_d = {rx_s_q, shift_q[7:1]};
        bit_d = bit_q + 3'd1;
        cnt_d = FULL_BIT;
        state_d = (bit_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (expired) begin
        state_d = IDLE;
        push = rx_s_q;
        frame_err = !rx_s_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // Synchronizer and receiver state; the line idles high so the sync flops reset to 1
  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q <= rx_meta_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
    end
  end
  assign bus_start = i_wb_cyc & !ack_q;
  assign nonempty = count_q != '0;
  assign full = count_q == NW'(DEPTH);
  assign pop = bus_start & !i_wb_we & !i_wb_adr & nonempty;
  assign push_ok = push & (!full | pop);
  assign clr_wr = bus_start & i_wb_we & i_wb_adr;
  assign count_d = count_q + NW'(push_ok) - NW'(pop);
  assign ovr_d = (push & full & !pop) | (ovr_q & !(clr_wr & i_wb_dat[2]));
  assign ferr_d = frame_err | (ferr_q & !(clr_wr & i_wb_dat[3]));
  assign rdt_d = !bus_start ? 32'd0 :
                 i_wb_adr ? {24'd0, 4'(count_q), ferr_q, ovr_q, full, nonempty} :
                 {23'd0, nonempty, nonempty ? mem_q[rd_q] : 8'h00};
  // FIFO storage needs no reset: entries are only visible once counted
  always_ff @(posedge i_wb_clk) begin
    if (push_ok) mem_q[wr_q] <= shift_q;
  end
  // FIFO pointers, sticky flags and the Wishbone response
  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      ovr_q <= 1'b0;
      ferr_q <= 1'b0;
      irq_q <= 1'b0;
      ack_q <= 1'b0;
      rdt_q <= '0;
    end else begin
      wr_q <= wr_q + FIFO_AW'(push_ok);
      rd_q <= rd_q + FIFO_AW'(pop);
      count_q <= count_d;
      ovr_q <= ovr_d;
      ferr_q <= ferr_d;
      irq_q <= count_d != '0;
      ack_q <= bus_start;
      rdt_q <= rdt_d;
    end
  end
  assign o_wb_rdt = rdt_q;
  assign o_wb_ack = ack_q;
  assign o_irq = irq_q;
endmodule

// File: tb/tb_servant_uart_rx.sv
// tb_servant_uart_rx: randomized self-checking bench for servant_uart_rx against a queue model
module tb_servant_uart_rx;
  localparam int C = 16;
  localparam int H = C / 2;
  localparam int S = 3 + H + 9 * C;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic adr = 1'b0;
  logic [31:0] dat = '0;
  logic we = 1'b0;
  logic cyc = 1'b0;
  logic [31:0] rdt;
  logic ack, irq;
  int checks = 0;
  int errors = 0;
  logic [7:0] mq[$];
  logic m_ovr, m_ferr;
  servant_uart_rx #(.CLKS_PER_BIT(C), .FIFO_AW(2)) dut (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_rx(rx), .i_wb_adr(adr),
    .i_wb_dat(dat), .i_wb_we(we), .i_wb_cyc(cyc),
    .o_wb_rdt(rdt), .o_wb_ack(ack), .o_irq(irq)
  );
  always #5 clk = ~clk;
  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  function automatic logic [31:0] m_status();
    logic [3:0] n;
    n = 4'(mq.size());
    return {24'd0, n, m_ferr, m_ovr, n == 4'd4, n != 4'd0};
  endfunction
  function automatic void m_frame(input logic [7:0] b, input logic stop);
    if (!stop) m_ferr = 1'b1;
    else if (mq.size() == 4) m_ovr = 1'b1;
    else mq.push_back(b);
  endfunction
  function automatic logic [31:0] m_pop();
    logic [31:0] r;
    r = 32'd0;
    if (mq.size() != 0) r = {23'd0, 1'b1, mq.pop_front()};
    return r;
  endfunction
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      #1 rx = f[i];
      repeat (C) @(posedge clk);
    end
    #1 rx = 1'b1;
    repeat (C) @(posedge clk);
  endtask
  task automatic wb_xfer(input logic a, input logic w, input logic [31:0] d, output logic [31:0] r, output logic k);
    @(posedge clk);
    #1 cyc = 1'b1; adr = a; we = w; dat = d;
    @(posedge clk);
    #1 r = rdt; k = ack;
    cyc = 1'b0; we = 1'b0; dat = '0;
    @(posedge clk);
  endtask
  task automatic aligned_xfer(input logic [7:0] b, input logic stop, input logic a, input logic w,
                              input logic [31:0] d, output logic [31:0] r, output logic k);
    logic [31:0] rr;
    logic kk;
    fork
      send_frame(b, stop);
      begin
        @(posedge clk);
        repeat (S - 2) @(posedge clk);
        wb_xfer(a, w, d, rr, kk);
      end
    join
    r = rr;
    k = kk;
  endtask
  task automatic test_reset();
    logic [31:0] r;
    logic k;
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", ack); end
    checks++; if (rdt !== 32'd0) begin errors++; $display("FAIL reset_rdt got %h exp 0", rdt); end
    rst_n = 1'b1;
    mq.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
    wb_xfer(1'b1, 1'b0, 32'd0, r, k);
    checks++; if (k !== 1'b1) begin errors++; $display("FAIL reset_ack_pulse got %b exp 1", k); end
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_status got %h exp 0", r); end
    #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ack_single_cycle got %b exp 0", ack); end
  endtask
  task automatic test_basic();
    logic [31:0] r;
    logic k;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge clk);
        repeat (S - 1) @(posedge clk);
        #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", irq); end
        @(posedge clk);
        #1;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_latency got %b exp 1", irq); end
      end
    join
    m_frame(8'hA5, 1'b1);
    wb_xfer(1'b0, 1'b0, 32'd0, r, k);
    checks++; if (r !== 32'h1A5 || r !== m_pop()) begin errors++; $display("FAIL basic_data got %h exp 1a5", r); end
    wb_xfer(1'b0, 1'b0, 32'd0, r, k);
    checks++; if (r !== m_pop()) begin errors++; $display("FAIL basic_empty got %h exp 0", r); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_low got %b exp 0", irq); end
    wb_xfer(1'b0, 1'b1, 32'hFF, r, k);
    checks++; if (k !== 1'b1) begin errors++; $display("FAIL data_write_ack got %b exp 1", k); end
    wb_xfer(1'b1, 1'b0, 32'd0, r, k);
    checks++; if (r !== m_status()) begin errors++; $display("FAIL data_write_noeffect got %h exp %h", r, m_status()); end
  endtask
  task automatic test_frame_error();
    logic [31:0] r;
    logic k;
    send_frame(8'h00, 1'b0);
    m_frame(8'h00, 1'b0);
    wb_xfer(1'b1, 1'b0, 32'd0, r, k);
    checks++; if (r !== 32'h08 || r !== m_status()) begin errors++; $display("FAIL ferr_status got %h exp 08", r); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ferr_irq got %b exp 0", irq); end
    wb_xfer(1'b1, 1'b1, 32'h8, r, k);
    m_ferr = 1'b0;
    wb_xfer(1'b1, 1'b0, 32'd0, r, k);
    checks++; if (r !== 32'h00) begin errors++; $display("FAIL ferr_clear got %h exp 00", r); end
    aligned_xfer(8'h55, 1'b0, 1'b1, 1'b1, 32'h8, r, k);
    m_frame(8'h55, 1'b0);
    wb_xfer(1'b1, 1'b0, 32'd0, r, k);
    checks++; if (r !== m_status()) begin errors++; $display("FAIL ferr_set_wins got %h exp %h", r, m_status()); end
    wb_xfer(1'b1, 1'b1, 32'hC, r, k);
    m_ferr = 1'b0;
  endtask
  task automatic test_overflow();
    logic [31:0] r;
    logic k;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      m_frame(8'(i), 1'b1);
    end
    wb_xfer(1'b1, 1'b0, 32'd0, r, k);
    checks++; if (r !== 32'h47 || r !== m_status()) begin errors++; $display("FAIL ovr_status got %h exp 47", r); end
    for (int i = 1; i <= 5; i++) begin
      wb_xfer(1'b0, 1'b0, 32'd0, r, k);
      checks++; if (r !== m_pop()) begin errors++; $display("FAIL ovr_read%0d got %h", i, r); end
    end
    wb_xfer(1'b1, 1'b1, 32'h4, r, k);
    m_ovr = 1'b0;
    wb_xfer(1'b1, 1'b0, 32'd0, r, k);
    checks++; if (r !== 32'h00) begin errors++; $display("FAIL ovr_clear got %h exp 00", r); end
  endtask
  task automatic test_glitch();
    logic [31:0] r;
    logic k;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (2 * C) @(posedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL glitch_irq got %b exp 0", irq); end
    wb_xfer(1'b1, 1'b0, 32'd0, r, k);
    checks++; if (r !== 32'h00) begin errors++; $display("FAIL glitch_status got %h exp 00", r); end
  endtask
  task automatic test_reset_midframe();
    logic [31:0] r;
    logic k;
    logic [9:0] f;
    send_frame(8'h77, 1'b1);
    f = {1'b1, 8'h3C, 1'b0};
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 rx = f[i];
      repeat (C) @(posedge clk);
    end
    #1 rx = f[4];
    repeat (H) @(posedge clk);
    #1 rst_n = 1'b0; rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mq.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
    repeat (2 * C) @(posedge clk);
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq got %b exp 0", irq); end
    wb_xfer(1'b1, 1'b0, 32'd0, r, k);
    checks++; if (r !== 32'h00) begin errors++; $display("FAIL midrst_status got %h exp 00", r); end
    send_frame(8'h3C, 1'b1);
    m_frame(8'h3C, 1'b1);
    wb_xfer(1'b0, 1'b0, 32'd0, r, k);
    checks++; if (r !== 32'h13C || r !== m_pop()) begin errors++; $display("FAIL midrst_next got %h exp 13c", r); end
  endtask
  task automatic test_pop_align();
    logic [31:0] r;
    logic k;
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      m_frame(b, 1'b1);
    end
    b = 8'($urandom);
    aligned_xfer(b, 1'b1, 1'b0, 1'b0, 32'd0, r, k);
    checks++; if (r !== m_pop()) begin errors++; $display("FAIL align_pop got %h", r); end
    m_frame(b, 1'b1);
    wb_xfer(1'b1, 1'b0, 32'd0, r, k);
    checks++; if (r !== 32'h43 || r !== m_status()) begin errors++; $display("FAIL align_status got %h exp 43", r); end
    for (int i = 0; i < 4; i++) begin
      wb_xfer(1'b0, 1'b0, 32'd0, r, k);
      checks++; if (r !== m_pop()) begin errors++; $display("FAIL align_order%0d got %h", i, r); end
    end
  endtask
  task automatic test_random();
    logic [31:0] r, e;
    logic k;
    logic [7:0] b;
    logic st;
    int n;
    for (int round = 0; round < 3; round++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        st = $urandom_range(0, 4) != 0;
        send_frame(b, st);
        m_frame(b, st);
      end
      e = m_status();
      wb_xfer(1'b1, 1'b0, 32'd0, r, k);
      checks++; if (r !== e) begin errors++; $display("FAIL rnd_status%0d got %h exp %h", round, r, e); end
      checks++; if (irq !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_irq%0d got %b", round, irq); end
      for (int i = 0; i < 5; i++) begin
        wb_xfer(1'b0, 1'b0, 32'd0, r, k);
        e = m_pop();
        checks++; if (r !== e) begin errors++; $display("FAIL rnd_data%0d_%0d got %h exp %h", round, i, r, e); end
      end
      wb_xfer(1'b1, 1'b1, 32'hC, r, k);
      m_ovr = 1'b0; m_ferr = 1'b0;
      wb_xfer(1'b1, 1'b0, 32'd0, r, k);
      checks++; if (r !== m_status()) begin errors++; $display("FAIL rnd_clear%0d got %h", round, r); end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_frame_error();
    test_overflow();
    test_glitch();
    test_reset_midframe();
    test_pop_align();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
